// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive constants, receiver state encoding and ASCII hex helpers.
//   ASCII_*         : byte constants used by the line parser
//   rx_state_t      : receiver FSM states
//   clks_per_bit()  : truncated clock-to-baud ratio
//   ascii_to_nibble : ASCII hex character to nibble, with is_hex flag
package uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LF_HEX = 8'h66;
    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_UF    = 8'h46;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       is_hex;
        logic [3:0] nibble;
    } hex_nibble_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Inverse of the transmit-side hex table; accepts both letter cases.
    function automatic hex_nibble_t ascii_to_nibble(input logic [7:0] c);
        hex_nibble_t r;
        r = '0;
        if (c >= ASCII_0 && c <= ASCII_9) begin
            r.is_hex = 1'b1;
            r.nibble = 4'(c - ASCII_0);
        end else if (c >= ASCII_LA && c <= ASCII_LF_HEX) begin
            r.is_hex = 1'b1;
            r.nibble = 4'(c - ASCII_LA + 8'd10);
        end else if (c >= ASCII_UA && c <= ASCII_UF) begin
            r.is_hex = 1'b1;
            r.nibble = 4'(c - ASCII_UA + 8'd10);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_V2.sv
// uart_rx_V2: 8N1 UART receiver with 2-FF input synchroniser and mid-bit sampling.
//   print_clk : clock
//   rst_n     : asynchronous active-low reset
//   rx        : raw UART line, idle high
//   rx_byte   : last received byte, valid with rx_strobe
//   rx_strobe : one-cycle pulse for a byte with a good stop bit
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : receiver is not in RX_IDLE
module uart_rx_V2
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       print_clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, next_state;
    logic          sync1, sync2;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic          tick;

    // The start state waits half a bit so later samples land mid-bit.
    assign tick = (state == RX_START) ? (clk_cnt == HALF) : (clk_cnt == FULL);
    assign busy = (state != RX_IDLE);

    always_ff @(posedge print_clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RX_IDLE:  next_state = sync2 ? RX_IDLE : RX_START;
            RX_START: next_state = !tick ? RX_START : (sync2 ? RX_IDLE : RX_DATA);
            RX_DATA:  next_state = (tick && bit_cnt == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP:  next_state = tick ? RX_IDLE : RX_STOP;
            default:  next_state = RX_IDLE;
        endcase
    end

    // bit_cnt leaves RX_DATA having wrapped back to 0, ready for the next byte.
    always_ff @(posedge print_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            clk_cnt   <= (state == RX_IDLE || tick) ? '0 : clk_cnt + 1'b1;
            rx_strobe <= (state == RX_STOP) && tick && sync2;
            frame_err <= (state == RX_STOP) && tick && !sync2;
            if (state == RX_DATA && tick) begin
                rx_byte <= {sync2, rx_byte[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_module.sv
// scan_module: UART receiver plus ASCII hex line parser producing binary words.
//   print_clk  : clock
//   rst_n      : asynchronous active-low reset
//   uart_rxp   : UART receive line, idle high
//   word_out   : parsed word, right-justified, zero-extended, held until next word_valid
//   word_len   : digit count of word_out
//   word_valid : one-cycle pulse when a good line terminates
//   line_err   : one-cycle pulse when a rejected line terminates
//   frame_err  : one-cycle pulse on a low stop bit
//   rx_busy    : receiver is mid-byte
module scan_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 27000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int MAX_DIGITS   = 8
) (
    input  logic                    print_clk,
    input  logic                    rst_n,
    input  logic                    uart_rxp,
    output logic [4*MAX_DIGITS-1:0] word_out,
    output logic [3:0]              word_len,
    output logic                    word_valid,
    output logic                    line_err,
    output logic                    frame_err,
    output logic                    rx_busy
);

    localparam int W = 4 * MAX_DIGITS;

    logic [7:0]   rx_byte;
    logic         rx_strobe;
    logic [W-1:0] acc;
    logic [3:0]   count;
    logic         err;
    hex_nibble_t  hn;
    logic         is_term;

    uart_rx_V2 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .print_clk (print_clk),
        .rst_n     (rst_n),
        .rx        (uart_rxp),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err),
        .busy      (rx_busy)
    );

    assign hn      = ascii_to_nibble(rx_byte);
    assign is_term = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);

    // An empty line at a terminator emits nothing, so CRLF yields a single word.
    always_ff @(posedge print_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            count      <= '0;
            err        <= 1'b0;
            word_out   <= '0;
            word_len   <= '0;
            word_valid <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            line_err   <= 1'b0;
            if (rx_strobe) begin
                if (hn.is_hex) begin
                    if (count >= 4'(MAX_DIGITS)) begin
                        err <= 1'b1;
                    end else begin
                        acc   <= {acc[W-5:0], hn.nibble};
                        count <= count + 1'b1;
                    end
                end else if (is_term) begin
                    line_err <= err;
                    if (!err && count != '0) begin
                        word_out   <= acc;
                        word_len   <= count;
                        word_valid <= 1'b1;
                    end
                    acc   <= '0;
                    count <= '0;
                    err   <= 1'b0;
                end else if (rx_byte != ASCII_SPACE) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_module.sv
// tb_scan_module: directed and randomized line tests for scan_module against a string-level parser model.
module tb_scan_module;

    localparam int CPB = 108;

    logic        print_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        uart_rxp  = 1'b1;
    logic [31:0] word_out;
    logic [3:0]  word_len;
    logic        word_valid, line_err, frame_err, rx_busy;

    int nvec = 0, nerr = 0;
    int cyc = 0, strobe_cyc = -10, n_strobe = 0, n_valid = 0, n_lerr = 0, n_ferr = 0, lat_bad = 0;
    logic [31:0] got_word = '0;
    logic [3:0]  got_len = '0;
    logic [31:0] exp_word = '0;
    logic [3:0]  exp_len = '0;

    always #5 print_clk = ~print_clk;

    scan_module #(.CLK_FREQ(27000000), .BAUD(250000), .MAX_DIGITS(8)) dut (
        .print_clk  (print_clk),
        .rst_n      (rst_n),
        .uart_rxp   (uart_rxp),
        .word_out   (word_out),
        .word_len   (word_len),
        .word_valid (word_valid),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    // Event monitor: records pulses and checks the one-cycle strobe-to-result latency.
    always @(negedge print_clk) begin
        cyc++;
        if (dut.u_rx.rx_strobe) begin
            strobe_cyc = cyc;
            n_strobe++;
        end
        if (word_valid) begin
            n_valid++;
            got_word = word_out;
            got_len  = word_len;
            if (cyc != strobe_cyc + 1) lat_bad++;
        end
        if (line_err) begin
            n_lerr++;
            if (cyc != strobe_cyc + 1) lat_bad++;
        end
        if (frame_err) n_ferr++;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge print_clk);
        uart_rxp = 1'b0;
        repeat (CPB) @(negedge print_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxp = b[i];
            repeat (CPB) @(negedge print_clk);
        end
        uart_rxp = stop_ok;
        if (stop_ok) begin
            repeat (CPB) @(negedge print_clk);
        end else begin
            repeat (CPB / 2 + 10) @(negedge print_clk);
            uart_rxp = 1'b1;
            repeat (CPB) @(negedge print_clk);
        end
        uart_rxp = 1'b1;
        repeat (2) @(negedge print_clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    // Parser reference: kind 0 = nothing, 1 = word, 2 = line error.
    function automatic void model(input byte q[$], output int kind, output logic [31:0] val, output int len);
        int nd = 0;
        bit bad = 0;
        int d;
        val = '0;
        foreach (q[i]) begin
            if (q[i] >= "0" && q[i] <= "9") d = q[i] - 48;
            else if (q[i] >= "a" && q[i] <= "f") d = q[i] - 87;
            else if (q[i] >= "A" && q[i] <= "F") d = q[i] - 55;
            else d = -1;
            if (d >= 0) begin
                nd++;
                if (nd <= 8) val = val * 16 + 32'(d);
            end else if (q[i] != " ") begin
                bad = 1;
            end
        end
        kind = (bad || nd > 8) ? 2 : (nd > 0 ? 1 : 0);
        len  = nd;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge print_clk);
        nvec++; if (word_out !== 32'h0) begin nerr++; $display("FAIL reset_word_out got %h exp 0", word_out); end
        nvec++; if (word_len !== 4'h0) begin nerr++; $display("FAIL reset_word_len got %h exp 0", word_len); end
        nvec++; if (word_valid !== 1'b0) begin nerr++; $display("FAIL reset_word_valid got %b exp 0", word_valid); end
        nvec++; if (line_err !== 1'b0) begin nerr++; $display("FAIL reset_line_err got %b exp 0", line_err); end
        nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL reset_rx_busy got %b exp 0", rx_busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge print_clk);
    endtask

    task automatic test_basic();
        int v0 = n_valid, l0 = n_lerr;
        send_str("1a2B");
        send_byte(8'h0D, 1'b1);
        repeat (4) @(negedge print_clk);
        exp_word = 32'h00001A2B; exp_len = 4'd4;
        nvec++; if (n_valid - v0 !== 1) begin nerr++; $display("FAIL basic_valid_count got %0d exp 1", n_valid - v0); end
        nvec++; if (got_word !== exp_word) begin nerr++; $display("FAIL basic_word got %h exp %h", got_word, exp_word); end
        nvec++; if (got_len !== exp_len) begin nerr++; $display("FAIL basic_len got %0d exp %0d", got_len, exp_len); end
        nvec++; if (n_lerr - l0 !== 0) begin nerr++; $display("FAIL basic_line_err got %0d exp 0", n_lerr - l0); end
        nvec++; if (lat_bad !== 0) begin nerr++; $display("FAIL basic_latency got %0d late pulses exp 0", lat_bad); end
    endtask

    task automatic test_crlf();
        int v0 = n_valid, l0 = n_lerr;
        send_str("FF");
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        repeat (4) @(negedge print_clk);
        exp_word = 32'h000000FF; exp_len = 4'd2;
        nvec++; if (n_valid - v0 !== 1) begin nerr++; $display("FAIL crlf_valid_count got %0d exp 1", n_valid - v0); end
        nvec++; if (got_word !== exp_word) begin nerr++; $display("FAIL crlf_word got %h exp %h", got_word, exp_word); end
        nvec++; if (got_len !== exp_len) begin nerr++; $display("FAIL crlf_len got %0d exp %0d", got_len, exp_len); end
        nvec++; if (n_lerr - l0 !== 0) begin nerr++; $display("FAIL crlf_line_err got %0d exp 0", n_lerr - l0); end
    endtask

    task automatic test_overflow();
        int v0 = n_valid, l0 = n_lerr;
        send_str("123456789");
        send_byte(8'h0A, 1'b1);
        repeat (4) @(negedge print_clk);
        nvec++; if (n_lerr - l0 !== 1) begin nerr++; $display("FAIL ovf_line_err got %0d exp 1", n_lerr - l0); end
        nvec++; if (n_valid - v0 !== 0) begin nerr++; $display("FAIL ovf_valid_count got %0d exp 0", n_valid - v0); end
        nvec++; if (word_out !== exp_word) begin nerr++; $display("FAIL ovf_word_hold got %h exp %h", word_out, exp_word); end
        nvec++; if (word_len !== exp_len) begin nerr++; $display("FAIL ovf_len_hold got %0d exp %0d", word_len, exp_len); end
    endtask

    task automatic test_bad_char();
        int v0 = n_valid, l0 = n_lerr;
        send_str("12G4");
        send_byte(8'h0D, 1'b1);
        repeat (4) @(negedge print_clk);
        nvec++; if (n_lerr - l0 !== 1) begin nerr++; $display("FAIL badch_line_err got %0d exp 1", n_lerr - l0); end
        nvec++; if (n_valid - v0 !== 0) begin nerr++; $display("FAIL badch_valid_count got %0d exp 0", n_valid - v0); end
        v0 = n_valid;
        send_str("7");
        send_byte(8'h0D, 1'b1);
        repeat (4) @(negedge print_clk);
        exp_word = 32'h7; exp_len = 4'd1;
        nvec++; if (n_valid - v0 !== 1) begin nerr++; $display("FAIL badch_recover_count got %0d exp 1", n_valid - v0); end
        nvec++; if (got_word !== exp_word) begin nerr++; $display("FAIL badch_recover_word got %h exp %h", got_word, exp_word); end
        nvec++; if (got_len !== exp_len) begin nerr++; $display("FAIL badch_recover_len got %0d exp %0d", got_len, exp_len); end
    endtask

    task automatic test_frame_err();
        int f0 = n_ferr, s0 = n_strobe, v0;
        send_byte(8'h41, 1'b0);
        repeat (4) @(negedge print_clk);
        nvec++; if (n_ferr - f0 !== 1) begin nerr++; $display("FAIL frame_err_count got %0d exp 1", n_ferr - f0); end
        nvec++; if (n_strobe - s0 !== 0) begin nerr++; $display("FAIL frame_strobe_count got %0d exp 0", n_strobe - s0); end
        v0 = n_valid;
        send_str("5");
        send_byte(8'h0D, 1'b1);
        repeat (4) @(negedge print_clk);
        exp_word = 32'h5; exp_len = 4'd1;
        nvec++; if (n_valid - v0 !== 1) begin nerr++; $display("FAIL frame_recover_count got %0d exp 1", n_valid - v0); end
        nvec++; if (got_word !== exp_word) begin nerr++; $display("FAIL frame_recover_word got %h exp %h", got_word, exp_word); end
    endtask

    task automatic test_glitch();
        int s0 = n_strobe, f0 = n_ferr, l0 = n_lerr, v0 = n_valid;
        @(negedge print_clk);
        uart_rxp = 1'b0;
        repeat (50) @(negedge print_clk);
        uart_rxp = 1'b1;
        repeat (CPB) @(negedge print_clk);
        nvec++; if (n_strobe - s0 !== 0) begin nerr++; $display("FAIL glitch_strobe got %0d exp 0", n_strobe - s0); end
        nvec++; if (n_ferr - f0 !== 0) begin nerr++; $display("FAIL glitch_frame_err got %0d exp 0", n_ferr - f0); end
        nvec++; if (n_lerr - l0 + n_valid - v0 !== 0) begin nerr++; $display("FAIL glitch_parser_events got %0d exp 0", n_lerr - l0 + n_valid - v0); end
        nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL glitch_busy got %b exp 0", rx_busy); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b3 = 8'h33;
        int v0;
        send_str("9");
        @(negedge print_clk);
        uart_rxp = 1'b0;
        repeat (CPB) @(negedge print_clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxp = b3[i];
            repeat (CPB) @(negedge print_clk);
        end
        uart_rxp = b3[4];
        repeat (CPB / 2) @(negedge print_clk);
        nvec++; if (rx_busy !== 1'b1) begin nerr++; $display("FAIL midbyte_busy got %b exp 1", rx_busy); end
        rst_n = 1'b0;
        #1;
        nvec++; if (word_out !== 32'h0) begin nerr++; $display("FAIL midrst_word_out got %h exp 0", word_out); end
        nvec++; if (word_len !== 4'h0) begin nerr++; $display("FAIL midrst_word_len got %h exp 0", word_len); end
        nvec++; if ({word_valid, line_err, frame_err, rx_busy} !== 4'b0) begin nerr++; $display("FAIL midrst_flags got %b exp 0000", {word_valid, line_err, frame_err, rx_busy}); end
        uart_rxp = 1'b1;
        repeat (3) @(negedge print_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge print_clk);
        v0 = n_valid;
        send_str("3");
        send_byte(8'h0D, 1'b1);
        repeat (4) @(negedge print_clk);
        exp_word = 32'h3; exp_len = 4'd1;
        nvec++; if (n_valid - v0 !== 1) begin nerr++; $display("FAIL postrst_count got %0d exp 1", n_valid - v0); end
        nvec++; if (got_word !== exp_word) begin nerr++; $display("FAIL postrst_word got %h exp %h", got_word, exp_word); end
        nvec++; if (got_len !== exp_len) begin nerr++; $display("FAIL postrst_len got %0d exp %0d", got_len, exp_len); end
    endtask

    task automatic test_random();
        string hexs = "0123456789abcdef";
        string bads = "Gz-x";
        for (int n = 0; n < 4; n++) begin
            byte q[$];
            int kind, len, v0, l0, nch, r;
            logic [31:0] val;
            byte c;
            q = {};
            nch = $urandom_range(1, 9);
            for (int i = 0; i < nch; i++) begin
                r = $urandom_range(0, 21);
                if (r < 18) begin
                    c = hexs[$urandom_range(0, 15)];
                    if (c >= "a" && $urandom_range(0, 1) == 1) c = c - 8'sd32;
                end else if (r < 20) begin
                    c = " ";
                end else begin
                    c = bads[$urandom_range(0, 3)];
                end
                q.push_back(c);
            end
            model(q, kind, val, len);
            v0 = n_valid;
            l0 = n_lerr;
            foreach (q[i]) send_byte(q[i], 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                send_byte(8'h0D, 1'b1);
                if ($urandom_range(0, 1) == 1) send_byte(8'h0A, 1'b1);
            end else begin
                send_byte(8'h0A, 1'b1);
            end
            repeat (4) @(negedge print_clk);
            if (kind == 1) begin
                exp_word = val;
                exp_len  = 4'(len);
            end
            nvec++; if (n_valid - v0 !== int'(kind == 1)) begin nerr++; $display("FAIL rand%0d_valid_count got %0d exp %0d", n, n_valid - v0, int'(kind == 1)); end
            nvec++; if (n_lerr - l0 !== int'(kind == 2)) begin nerr++; $display("FAIL rand%0d_line_err got %0d exp %0d", n, n_lerr - l0, int'(kind == 2)); end
            nvec++; if (word_out !== exp_word) begin nerr++; $display("FAIL rand%0d_word got %h exp %h", n, word_out, exp_word); end
            nvec++; if (word_len !== exp_len) begin nerr++; $display("FAIL rand%0d_len got %0d exp %0d", n, word_len, exp_len); end
        end
        nvec++; if (lat_bad !== 0) begin nerr++; $display("FAIL latency_total got %0d late pulses exp 0", lat_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crlf();
        test_overflow();
        test_bad_char();
        test_frame_err();
        test_glitch();
        test_reset_mid_byte();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
